// File: rtl/mem_access_unit_if.sv
// CPU-side request/response and memory-side bus signals of mem_access_unit.
// The unit uses the slave modport; the CPU/memory environment uses master.
interface mem_access_unit_if;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic [2:0]  reqMemOp;
    logic        reqWe;
    logic        respValid;
    logic [31:0] respRdata;
    logic        respErr;
    logic        busValid;
    logic        busReady;
    logic [31:0] busAddr;
    logic [31:0] busWdata;
    logic [3:0]  busWmask;
    logic        busWe;
    logic        busRvalid;
    logic [31:0] busRdata;

    modport master (
        output reqValid, reqAddr, reqWdata, reqMemOp, reqWe,
        output busReady, busRvalid, busRdata,
        input  reqReady, respValid, respRdata, respErr,
        input  busValid, busAddr, busWdata, busWmask, busWe
    );

    modport slave (
        input  reqValid, reqAddr, reqWdata, reqMemOp, reqWe,
        input  busReady, busRvalid, busRdata,
        output reqReady, respValid, respRdata, respErr,
        output busValid, busAddr, busWdata, busWmask, busWe
    );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/half/word load-store unit between a CPU request port and a word memory bus.
// Optional wait timeout enabled by defining MAU_TIMEOUT_EN.
//
// state     | meaning
// S_IDLE    | ready for a request, decode and latch it
// S_ISSUE   | bus request held until busReady
// S_WAIT_RD | load issued, waiting for busRvalid
// S_RESP    | one-cycle good completion
// S_ERR     | one-cycle error completion (bad op, misaligned or timeout)
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic                clk,
    input logic                rstn,
    mem_access_unit_if.slave   mau
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_RESP, S_ERR} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] addr_q, wdata_q, rdata_q, rd_shift, load_ext;
    logic [2:0]  op_q;
    logic        we_q, req_bad, tmo_hit, bus_valid;
    logic [4:0]  lane_shift;
    logic [3:0]  mask_raw;

    always_comb begin
        req_bad = 1'b0;
        case (mau.reqMemOp)
            3'd0, 3'd4: req_bad = 1'b0;
            3'd1, 3'd5: req_bad = mau.reqAddr[0];
            3'd2:       req_bad = (mau.reqAddr[1:0] != 2'b00);
            default:    req_bad = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (mau.reqValid) state_d = req_bad ? S_ERR : S_ISSUE;
            S_ISSUE: begin
                if (mau.busReady)  state_d = we_q ? S_RESP : S_WAIT_RD;
                else if (tmo_hit)  state_d = S_ERR;
            end
            S_WAIT_RD: begin
                if (mau.busRvalid) state_d = S_RESP;
                else if (tmo_hit)  state_d = S_ERR;
            end
            S_RESP:    state_d = S_IDLE;
            S_ERR:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

`ifdef MAU_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        waiting;

    assign waiting = (state_q == S_ISSUE) || (state_q == S_WAIT_RD);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            tmo_cnt <= '0;
        else if ((state_d != state_q) && ((state_d == S_ISSUE) || (state_d == S_WAIT_RD)))
            tmo_cnt <= '0;
        else if (waiting)
            tmo_cnt <= tmo_cnt + 16'd1;
    end

    // Fires on the TIMEOUT-th cycle spent waiting in the current state.
    assign tmo_hit = waiting && (tmo_cnt == TMO_LAST);
`else
    logic unused_tmo_last;
    assign unused_tmo_last = ^TMO_LAST;
    assign tmo_hit = 1'b0;
`endif

    assign lane_shift = {addr_q[1:0], 3'b000};
    assign rd_shift   = mau.busRdata >> lane_shift;

    always_comb begin
        load_ext = rd_shift;
        case (op_q)
            3'd0:    load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'd1:    load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'd4:    load_ext = {24'd0, rd_shift[7:0]};
            3'd5:    load_ext = {16'd0, rd_shift[15:0]};
            default: load_ext = rd_shift;
        endcase
    end

    always_comb begin
        mask_raw = 4'b1111;
        case (op_q)
            3'd0, 3'd4: mask_raw = 4'b0001 << addr_q[1:0];
            3'd1, 3'd5: mask_raw = 4'b0011 << addr_q[1:0];
            default:    mask_raw = 4'b1111;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (state_q == S_IDLE && mau.reqValid) begin
                addr_q  <= mau.reqAddr;
                wdata_q <= mau.reqWdata;
                op_q    <= mau.reqMemOp;
                we_q    <= mau.reqWe;
            end
            // Result register only moves when a completion is about to be presented.
            if ((state_d == S_RESP || state_d == S_ERR) && state_q != state_d)
                rdata_q <= (state_d == S_RESP && state_q == S_WAIT_RD) ? load_ext : 32'd0;
        end
    end

    // Bus fields are gated so they read zero whenever no request is on the bus.
    assign bus_valid    = (state_q == S_ISSUE);
    assign mau.busValid = bus_valid;
    assign mau.busAddr  = bus_valid ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mau.busWdata = bus_valid ? (wdata_q << lane_shift) : 32'd0;
    assign mau.busWmask = (bus_valid && we_q) ? mask_raw : 4'b0000;
    assign mau.busWe    = bus_valid && we_q;

    assign mau.reqReady  = (state_q == S_IDLE);
    assign mau.respValid = (state_q == S_RESP) || (state_q == S_ERR);
    assign mau.respErr   = (state_q == S_ERR);
    assign mau.respRdata = rdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit against a one-word memory model.
// Define MAU_TIMEOUT_EN for both bench and RTL to also exercise the read timeout.
module tb_mem_access_unit;
    localparam logic [31:0] MEM_WORD = 32'h8899AABB;

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_errors;

    logic [31:0] r_rdata, r_bus_addr, r_bus_wdata;
    logic [3:0]  r_bus_wmask;
    logic        r_err, r_bus_we, r_bus_seen, r_unstable;
    int          r_lat;

    mem_access_unit_if mau_if();

    mem_access_unit #(.TIMEOUT(255)) dut (
        .clk  (clk),
        .rstn (rstn),
        .mau  (mau_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Presents one request and plays a memory that raises busReady after ready_delay
    // busValid cycles and returns MEM_WORD the cycle after a read handshake.
    task automatic do_access(input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [2:0] op, input logic we, input int ready_delay);
        logic got, rv_next;
        int   waited;
        got = 1'b0; rv_next = 1'b0; waited = 0;
        r_bus_seen = 1'b0; r_unstable = 1'b0; r_lat = -1;
        r_rdata = '0; r_err = 1'b0;
        r_bus_addr = '0; r_bus_wdata = '0; r_bus_wmask = '0; r_bus_we = 1'b0;
        mau_if.reqValid = 1'b1; mau_if.reqAddr = addr; mau_if.reqWdata = wdata;
        mau_if.reqMemOp = op;   mau_if.reqWe = we;
        check_val("req_ready_idle", {31'd0, mau_if.reqReady}, 32'd1);
        cycle();
        mau_if.reqValid = 1'b0;
        for (int c = 1; c <= 60 && !got; c++) begin
            mau_if.busRvalid = rv_next;
            mau_if.busRdata  = rv_next ? MEM_WORD : 32'd0;
            rv_next = 1'b0;
            mau_if.busReady = 1'b0;
            if (mau_if.respValid) begin
                got = 1'b1; r_lat = c; r_rdata = mau_if.respRdata; r_err = mau_if.respErr;
            end else if (mau_if.busValid) begin
                if (!r_bus_seen) begin
                    r_bus_seen = 1'b1;
                    r_bus_addr = mau_if.busAddr; r_bus_wdata = mau_if.busWdata;
                    r_bus_wmask = mau_if.busWmask; r_bus_we = mau_if.busWe;
                end else if (mau_if.busAddr !== r_bus_addr || mau_if.busWdata !== r_bus_wdata ||
                             mau_if.busWmask !== r_bus_wmask || mau_if.busWe !== r_bus_we) begin
                    r_unstable = 1'b1;
                end
                if (waited >= ready_delay) begin
                    mau_if.busReady = 1'b1;
                    if (!mau_if.busWe) rv_next = 1'b1;
                end
                waited++;
            end
            cycle();
        end
        mau_if.busReady = 1'b0; mau_if.busRvalid = 1'b0; mau_if.busRdata = '0;
        check_val("resp_seen", {31'd0, got}, 32'd1);
        check_val("resp_one_cycle", {31'd0, mau_if.respValid}, 32'd0);
        check_val("rdata_hold", mau_if.respRdata, r_rdata);
    endtask

    task automatic check_load(input string tag, input logic [31:0] addr, input logic [2:0] op,
                              input logic [31:0] exp_rdata);
        do_access(addr, 32'd0, op, 1'b0, 0);
        check_val({tag, "_rdata"}, r_rdata, exp_rdata);
        check_val({tag, "_err"}, {31'd0, r_err}, 32'd0);
        check_val({tag, "_lat"}, r_lat, 32'd3);
        check_val({tag, "_addr"}, r_bus_addr, {addr[31:2], 2'b00});
        check_val({tag, "_mask"}, {28'd0, r_bus_wmask}, 32'd0);
    endtask

    initial begin
        int cnt;
        logic seen;
        n_checks = 0; n_errors = 0;
        rstn = 1'b0;
        mau_if.reqValid = 1'b0; mau_if.reqAddr = '0; mau_if.reqWdata = '0;
        mau_if.reqMemOp = '0;   mau_if.reqWe = 1'b0;
        mau_if.busReady = 1'b0; mau_if.busRvalid = 1'b0; mau_if.busRdata = '0;
        #23;
        check_val("rst_req_ready", {31'd0, mau_if.reqReady}, 32'd1);
        check_val("rst_resp_valid", {31'd0, mau_if.respValid}, 32'd0);
        check_val("rst_resp_err", {31'd0, mau_if.respErr}, 32'd0);
        check_val("rst_resp_rdata", mau_if.respRdata, 32'd0);
        check_val("rst_bus_valid", {31'd0, mau_if.busValid}, 32'd0);
        check_val("rst_bus_addr", mau_if.busAddr, 32'd0);
        check_val("rst_bus_wdata", mau_if.busWdata, 32'd0);
        check_val("rst_bus_wmask", {28'd0, mau_if.busWmask}, 32'd0);
        check_val("rst_bus_we", {31'd0, mau_if.busWe}, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        cycle();

        check_load("lb_101",  32'h101, 3'd0, 32'hFFFFFFAA);
        check_load("lhu_102", 32'h102, 3'd5, 32'h00008899);
        check_load("lw_100",  32'h100, 3'd2, 32'h8899AABB);
        check_load("lh_100",  32'h100, 3'd1, 32'hFFFFAABB);
        check_load("lbu_103", 32'h103, 3'd4, 32'h00000088);
        check_load("lb_100",  32'h100, 3'd0, 32'hFFFFFFBB);
        check_load("lh_102",  32'h102, 3'd1, 32'hFFFF8899);

        do_access(32'h103, 32'h12, 3'd0, 1'b1, 0);
        check_val("sb_wdata", r_bus_wdata, 32'h12000000);
        check_val("sb_mask", {28'd0, r_bus_wmask}, 32'h8);
        check_val("sb_we", {31'd0, r_bus_we}, 32'd1);
        check_val("sb_addr", r_bus_addr, 32'h100);
        check_val("sb_lat", r_lat, 32'd2);
        check_val("sb_err", {31'd0, r_err}, 32'd0);
        check_val("sb_rdata", r_rdata, 32'd0);

        do_access(32'h102, 32'hBEEF, 3'd1, 1'b1, 3);
        check_val("sh_wdata", r_bus_wdata, 32'hBEEF0000);
        check_val("sh_mask", {28'd0, r_bus_wmask}, 32'hC);
        check_val("sh_stable", {31'd0, r_unstable}, 32'd0);
        check_val("sh_lat", r_lat, 32'd5);

        do_access(32'h100, 32'hCAFEF00D, 3'd2, 1'b1, 0);
        check_val("sw_wdata", r_bus_wdata, 32'hCAFEF00D);
        check_val("sw_mask", {28'd0, r_bus_wmask}, 32'hF);

        do_access(32'h102, 32'd0, 3'd2, 1'b0, 0);
        check_val("lw_mis_err", {31'd0, r_err}, 32'd1);
        check_val("lw_mis_lat", r_lat, 32'd1);
        check_val("lw_mis_nobus", {31'd0, r_bus_seen}, 32'd0);
        check_val("lw_mis_rdata", r_rdata, 32'd0);

        do_access(32'h100, 32'd0, 3'd3, 1'b0, 0);
        check_val("op3_err", {31'd0, r_err}, 32'd1);
        check_val("op3_nobus", {31'd0, r_bus_seen}, 32'd0);

        do_access(32'h101, 32'h55, 3'd5, 1'b1, 0);
        check_val("shu_mis_err", {31'd0, r_err}, 32'd1);

        mau_if.busRvalid = 1'b1; mau_if.busRdata = MEM_WORD;
        cycle();
        mau_if.busRvalid = 1'b0;
        check_val("rvalid_idle_ignored", {31'd0, mau_if.respValid}, 32'd0);

        // Abandon a load in WAIT_RD with an async reset pulse.
        mau_if.reqValid = 1'b1; mau_if.reqAddr = 32'h100; mau_if.reqMemOp = 3'd2; mau_if.reqWe = 1'b0;
        cycle();
        mau_if.reqValid = 1'b0;
        check_val("abort_issue_valid", {31'd0, mau_if.busValid}, 32'd1);
        check_val("abort_issue_ready", {31'd0, mau_if.reqReady}, 32'd0);
        mau_if.busReady = 1'b1;
        cycle();
        mau_if.busReady = 1'b0;
        check_val("abort_wait_resp", {31'd0, mau_if.respValid}, 32'd0);
        rstn = 1'b0;
        #2;
        check_val("abort_bus_valid", {31'd0, mau_if.busValid}, 32'd0);
        check_val("abort_req_ready", {31'd0, mau_if.reqReady}, 32'd1);
        rstn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (mau_if.respValid) seen = 1'b1;
        end
        check_val("abort_no_resp", {31'd0, seen}, 32'd0);
        check_load("post_abort_lw", 32'h100, 3'd2, 32'h8899AABB);

`ifdef MAU_TIMEOUT_EN
        mau_if.reqValid = 1'b1; mau_if.reqAddr = 32'h100; mau_if.reqMemOp = 3'd2; mau_if.reqWe = 1'b0;
        cycle();
        mau_if.reqValid = 1'b0;
        mau_if.busReady = 1'b1;
        cycle();
        mau_if.busReady = 1'b0;
        cnt = 0;
        while (!mau_if.respValid && cnt < 400) begin
            cnt++;
            cycle();
        end
        check_val("tmo_cycles", cnt, 32'd255);
        check_val("tmo_err", {31'd0, mau_if.respErr}, 32'd1);
        check_val("tmo_rdata", mau_if.respRdata, 32'd0);
        cycle();
`else
        cnt = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: TIMEOUT, 255, max cycles waiting in ISSUE or WAIT_RD before error; range 1..65535.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 rstn  input  1  asynchronous active-low reset.
REQ-004 reqValid  input  1  CPU access request valid.
REQ-005 reqReady  output  1  unit can accept a request (high only in IDLE).
REQ-006 reqAddr  input  32  byte address.
REQ-007 reqWdata  input  32  store data, right-aligned.
REQ-008 reqMemOp  input  3  0 B, 1 H, 2 W, 4 BU, 5 HU; others illegal.
REQ-009 reqWe  input  1  1 store, 0 load.
REQ-010 respValid  output  1  one-cycle completion pulse.
REQ-011 respRdata  output  32  load result, extended; 0 for stores and errors.
REQ-012 respErr  output  1  misaligned, illegal op or timeout; qualified by respValid.
REQ-013 busValid  output  1  memory request valid.
REQ-014 busReady  input  1  memory accepts request.
REQ-015 busAddr  output  32  word address: {reqAddr[31:2],2'b00}.
REQ-016 busWdata  output  32  store data shifted left by 8*offset.
REQ-017 busWmask  output  4  byte lanes: B 0001<<off, H 0011<<off, W 1111; 0000 on loads.
REQ-018 busWe  output  1  write request.
REQ-019 busRvalid  input  1  read data valid; earliest the cycle after the busValid&busReady handshake.
REQ-020 busRdata  input  32  read word.

Function
REQ-021 FSM states: IDLE, ISSUE, WAIT_RD, RESP, ERR.
REQ-022 IDLE: reqReady=1; on reqValid, latch addr, wdata, memOp and we; offset=addr[1:0].
REQ-023 Illegal memOp, H with offset[0]=1, or W with offset!=0 -> ERR; no bus transaction.
REQ-024 Otherwise -> ISSUE; busValid=1 with busAddr/busWdata/busWmask/busWe held stable until busReady.
REQ-025 ISSUE handshake: store -> RESP; load -> WAIT_RD.
REQ-026 WAIT_RD: on busRvalid, capture busRdata>>(8*offset), sign-extend (B/H) or zero-extend (BU/HU), then -> RESP.
REQ-027 RESP: respValid=1, respErr=0 for exactly one cycle, then -> IDLE.
REQ-028 ERR: respValid=1, respErr=1, respRdata=0 for one cycle, then -> IDLE.
REQ-029 Minimum latency: accept to respValid = 2 cycles for a store, 3 cycles for a load, 1 cycle for an error.
REQ-030 reqValid outside IDLE is ignored; reqReady is low.
REQ-031 busRvalid outside WAIT_RD is ignored.
REQ-032 respRdata holds its value outside respValid; it updates only on completion.

Reset
REQ-033 rstn low -> IDLE immediately. Outputs: reqReady=1; all other outputs 0, including the bus fields. Timeout counter cleared.
REQ-034 Reset during ISSUE or WAIT_RD abandons the access; busValid drops asynchronously and no respValid is produced.

Configuration
REQ-035 Macro MAU_TIMEOUT_EN defined: a 16-bit counter clears on entry to ISSUE/WAIT_RD and increments each cycle in those states.
REQ-036 When the counter reaches TIMEOUT with the handshake or busRvalid still absent, the FSM enters ERR.
REQ-037 Macro MAU_TIMEOUT_EN undefined: no counter; ISSUE and WAIT_RD wait indefinitely; TIMEOUT unused.

Verification
REQ-038 Memory word 0x100=0x8899AABB; LB 0x101 -> busAddr 0x100, respRdata 0xFFFFFFAA, respErr 0.
REQ-039 LHU 0x102 on the same word -> respRdata 0x00008899; LW 0x100 -> 0x8899AABB at 3-cycle latency with zero-wait memory.
REQ-040 SB 0x103, wdata 0x12 -> busWdata 0x12000000, busWmask 1000, busWe 1; respValid 2 cycles after accept.
REQ-041 LW 0x102 and memOp 3 -> respErr 1 the next cycle; busValid never asserted.
REQ-042 busReady low for 3 cycles -> busValid and all bus fields constant until the handshake; with MAU_TIMEOUT_EN, busRvalid withheld -> respErr 1 after 255 cycles in WAIT_RD.
REQ-043 rstn pulsed low in WAIT_RD -> busValid 0, reqReady 1, no respValid; the next request completes normally.
